// File: rtl/dm_pkg.sv
// DMI request/response payload types shared between the DTM and the debug-module side.
package dm_pkg;

  localparam int unsigned AddrW = 7;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [1:0]       op;
  } dmi_req_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [1:0]       resp;
  } dmi_resp_t;

  localparam logic [1:0] DmiOpNop       = 2'd0;
  localparam logic [1:0] DmiOpRead      = 2'd1;
  localparam logic [1:0] DmiOpWrite     = 2'd2;
  localparam logic [1:0] DmiRespSuccess = 2'd0;
  localparam logic [1:0] DmiRespErr     = 2'd2;

endpackage

// File: rtl/dmi_reg_bridge.sv
// Turns DMI requests into single-outstanding register-bus accesses with a timeout.
// Optional macro DMI_REG_BRIDGE_ADDR_CHECK_EN rejects READ/WRITE above MaxAddr without a bus access.
module dmi_reg_bridge #(
  parameter logic [15:0] TimeoutCycles = 16'd256,
  parameter logic [6:0]  MaxAddr       = 7'h5F
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  dm_pkg::dmi_req_t  dmi_req_i,
  input  logic              dmi_req_valid_i,
  output logic              dmi_req_ready_o,
  output dm_pkg::dmi_resp_t dmi_resp_o,
  output logic              dmi_resp_valid_o,
  input  logic              dmi_resp_ready_i,
  output logic              reg_req_o,
  output logic              reg_we_o,
  output logic [6:0]        reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  input  logic              reg_ack_i,
  input  logic [31:0]       reg_rdata_i,
  input  logic              reg_err_i
);

  typedef enum logic [1:0] {Idle, Access, Resp} state_e;

  state_e      state;
  logic [15:0] cnt;
  logic        accept;
  logic        is_rw;
  logic        addr_bad;
  logic        timeout;

  // Ready is the only combinational output: accept is possible in Idle only.
  assign dmi_req_ready_o = (state == Idle);
  assign accept          = dmi_req_valid_i & dmi_req_ready_o;
  assign is_rw           = (dmi_req_i.op == dm_pkg::DmiOpRead) || (dmi_req_i.op == dm_pkg::DmiOpWrite);
  assign timeout         = (TimeoutCycles != 16'd0) && (cnt == TimeoutCycles - 16'd1);

`ifdef DMI_REG_BRIDGE_ADDR_CHECK_EN
  assign addr_bad = (dmi_req_i.addr > MaxAddr);
`else
  logic unused_max_addr;
  assign unused_max_addr = ^MaxAddr;
  assign addr_bad        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= Idle;
      cnt              <= 16'd0;
      reg_req_o        <= 1'b0;
      reg_we_o         <= 1'b0;
      reg_addr_o       <= 7'd0;
      reg_wdata_o      <= 32'd0;
      dmi_resp_valid_o <= 1'b0;
      dmi_resp_o       <= '0;
    end else begin
      case (state)
        Idle: begin
          if (accept) begin
            reg_addr_o  <= dmi_req_i.addr;
            reg_wdata_o <= dmi_req_i.data;
            reg_we_o    <= (dmi_req_i.op == dm_pkg::DmiOpWrite);
            cnt         <= 16'd0;
            if (is_rw && !addr_bad) begin
              state     <= Access;
              reg_req_o <= 1'b1;
            end else begin
              // NOP succeeds; reserved op or out-of-range address errors without touching the bus.
              state              <= Resp;
              dmi_resp_valid_o   <= 1'b1;
              dmi_resp_o.data    <= 32'd0;
              dmi_resp_o.resp    <= (dmi_req_i.op == dm_pkg::DmiOpNop) ?
                                    dm_pkg::DmiRespSuccess : dm_pkg::DmiRespErr;
            end
          end
        end
        Access: begin
          // An ack in the timeout cycle still completes the access normally.
          if (reg_ack_i) begin
            state            <= Resp;
            reg_req_o        <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_o.data  <= (reg_err_i || reg_we_o) ? 32'd0 : reg_rdata_i;
            dmi_resp_o.resp  <= reg_err_i ? dm_pkg::DmiRespErr : dm_pkg::DmiRespSuccess;
          end else if (timeout) begin
            state            <= Resp;
            reg_req_o        <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_o.data  <= 32'd0;
            dmi_resp_o.resp  <= dm_pkg::DmiRespErr;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        Resp: begin
          if (dmi_resp_ready_i) begin
            state            <= Idle;
            dmi_resp_valid_o <= 1'b0;
          end
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_reg_bridge.sv
// Table-driven bench for dmi_reg_bridge with a response scoreboard and a few hand-written corner sequences.
module tb_dmi_reg_bridge;

  localparam int TO = 4;
`ifdef DMI_REG_BRIDGE_ADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_ni;
  dm_pkg::dmi_req_t  dmi_req_i;
  logic              dmi_req_valid_i;
  logic              dmi_req_ready_o;
  dm_pkg::dmi_resp_t dmi_resp_o;
  logic              dmi_resp_valid_o;
  logic              dmi_resp_ready_i;
  logic              reg_req_o;
  logic              reg_we_o;
  logic [6:0]        reg_addr_o;
  logic [31:0]       reg_wdata_o;
  logic              reg_ack_i;
  logic [31:0]       reg_rdata_i;
  logic              reg_err_i;

  dmi_reg_bridge #(.TimeoutCycles(16'(TO)), .MaxAddr(7'h5F)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_ack_i(reg_ack_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          ack_dly;   // Access cycle index of the ack, -1 = never
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          hold;      // cycles with resp_ready low after valid
    bit          late_ack;  // inject an ack while the response is pending
    bit          bus;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  vec_t        vecs[10];
  logic [33:0] sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                              input int dly, input logic [31:0] rd, input logic err,
                              input logic [31:0] ed, input logic [1:0] er, input int hold, input bit late);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.ack_dly = dly; v.rdata = rd; v.err = err;
    v.exp_data = ed; v.exp_resp = er; v.hold = hold; v.late_ack = late;
    v.bus     = (op == 2'd1 || op == 2'd2) && !(ChkEn && a > 7'h5F);
    v.exp_lat = !v.bus ? 1 : (dly < 0 ? TO + 1 : dly + 2);
    v.exp_req = !v.bus ? 0 : (dly < 0 ? TO : dly + 1);
    return v;
  endfunction

  task automatic run(input int idx, input vec_t r);
    int lat;
    int reqcnt;
    logic [33:0] exp;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), 64'(dmi_req_ready_o), 64'd1);
    dmi_req_i       = '{addr: r.addr, data: r.data, op: r.op};
    dmi_req_valid_i = 1'b1;
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    sb.push_back({r.exp_data, r.exp_resp});
    if (r.bus) begin
      chk($sformatf("v%0d_addr", idx), 64'(reg_addr_o), 64'(r.addr));
      chk($sformatf("v%0d_we", idx), 64'(reg_we_o), 64'(r.op == 2'd2));
      if (r.op == 2'd2) chk($sformatf("v%0d_wdata", idx), 64'(reg_wdata_o), 64'(r.data));
    end
    lat = 1;
    reqcnt = 0;
    while (!dmi_resp_valid_o && lat < 20) begin
      if (reg_req_o) reqcnt++;
      reg_ack_i   = (r.ack_dly >= 0) && (lat - 1 == r.ack_dly);
      reg_rdata_i = r.rdata;
      reg_err_i   = r.err;
      @(negedge clk);
      lat++;
    end
    reg_ack_i = 1'b0;
    if (!dmi_resp_valid_o) begin
      chk($sformatf("v%0d_resp_timeout", idx), 64'd0, 64'd1);
      return;
    end
    chk($sformatf("v%0d_lat", idx), 64'(lat), 64'(r.exp_lat));
    chk($sformatf("v%0d_reqcycles", idx), 64'(reqcnt), 64'(r.exp_req));
    chk($sformatf("v%0d_req_drop", idx), 64'(reg_req_o), 64'd0);
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 64'd0, 64'd1);
      return;
    end
    exp = sb.pop_front();
    chk($sformatf("v%0d_resp", idx), 64'(dmi_resp_o), 64'(exp));
    for (int h = 0; h < r.hold; h++) begin
      reg_ack_i   = r.late_ack && (h == 0);
      reg_rdata_i = 32'hFFFF_FFFF;
      reg_err_i   = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_hold%0d_valid", idx, h), 64'(dmi_resp_valid_o), 64'd1);
      chk($sformatf("v%0d_hold%0d_resp", idx, h), 64'(dmi_resp_o), 64'(exp));
      chk($sformatf("v%0d_hold%0d_ready", idx, h), 64'(dmi_req_ready_o), 64'd0);
      chk($sformatf("v%0d_hold%0d_req", idx, h), 64'(reg_req_o), 64'd0);
    end
    reg_ack_i        = 1'b0;
    dmi_resp_ready_i = 1'b1;
    @(negedge clk);
    dmi_resp_ready_i = 1'b0;
    chk($sformatf("v%0d_post_valid", idx), 64'(dmi_resp_valid_o), 64'd0);
    chk($sformatf("v%0d_post_ready", idx), 64'(dmi_req_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; dmi_req_i = '0; dmi_req_valid_i = 1'b0; dmi_resp_ready_i = 1'b0;
    reg_ack_i = 1'b0; reg_rdata_i = 32'd0; reg_err_i = 1'b0;

    vecs[0] = mk(2'd1, 7'h11, 32'h0,        3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2'd0, 0, 1'b0);
    vecs[1] = mk(2'd2, 7'h10, 32'h1,        0, 32'h5555AAAA, 1'b0, 32'h0,        2'd0, 4, 1'b0);
    vecs[2] = mk(2'd1, 7'h22, 32'h0,       -1, 32'h0,        1'b0, 32'h0,        2'd2, 2, 1'b1);
    vecs[3] = mk(2'd3, 7'h05, 32'h77,       0, 32'h0,        1'b0, 32'h0,        2'd2, 0, 1'b0);
    vecs[4] = mk(2'd0, 7'h06, 32'h88,       0, 32'h0,        1'b0, 32'h0,        2'd0, 1, 1'b0);
    vecs[5] = mk(2'd1, 7'h3F, 32'h0,        1, 32'hFFFFFFFF, 1'b1, 32'h0,        2'd2, 0, 1'b0);
    vecs[6] = mk(2'd2, 7'h00, 32'hA5A5A5A5, 2, 32'h12121212, 1'b0, 32'h0,        2'd0, 0, 1'b0);
    vecs[7] = mk(2'd1, 7'h60, 32'h0,        0, 32'h12345678, 1'b0,
                 ChkEn ? 32'h0 : 32'h12345678, ChkEn ? 2'd2 : 2'd0, 0, 1'b0);
    vecs[8] = mk(2'd2, 7'h7F, 32'hCAFE0001, 0, 32'h0,        1'b0, 32'h0, ChkEn ? 2'd2 : 2'd0, 0, 1'b0);
    vecs[9] = mk(2'd1, 7'h5F, 32'h0,        0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2'd0, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("rst_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("rst_resp", 64'(dmi_resp_o), 64'd0);
    chk("rst_req", 64'(reg_req_o), 64'd0);
    chk("rst_bus", 64'({reg_we_o, reg_addr_o, reg_wdata_o}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run(i, vecs[i]);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Ack while Idle must be ignored.
    @(negedge clk);
    reg_ack_i = 1'b1; reg_rdata_i = 32'h13572468;
    @(negedge clk);
    reg_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_ack_ready", 64'(dmi_req_ready_o), 64'd1);
    chk("idle_ack_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("idle_ack_req", 64'(reg_req_o), 64'd0);

    // Asynchronous reset in the middle of an access.
    dmi_req_i = '{addr: 7'h11, data: 32'h0, op: 2'd1};
    dmi_req_valid_i = 1'b1;
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_req_pre", 64'(reg_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", 64'(reg_req_o), 64'd0);
    chk("mid_rst_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(dmi_req_ready_o), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_post_req", 64'(reg_req_o), 64'd0);
    chk("mid_post_valid", 64'(dmi_resp_valid_o), 64'd0);
    chk("mid_post_ready", 64'(dmi_req_ready_o), 64'd1);

    // The bridge must still serve requests after the reset.
    run(10, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
